// File: rtl/sccb_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sccb_init_sequencer
// Description : Table-driven camera bring-up controller for CoreSCCB. Waits
//               out power-up, checks the sensor product ID, walks a ROM table
//               of register writes and delay markers, then shares the SCCB
//               master with a single host request port.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_init_sequencer #(
    parameter logic [6:0] IP_ADDR       = 7'h21,
    parameter logic [7:0] ID_SUB_ADDR   = 8'h0A,
    parameter logic [7:0] ID_EXPECT     = 8'h76,
    parameter int         PWRUP_TICKS   = 3000,
    parameter int         DELAY_UNIT    = 300,
    parameter int         TIMEOUT_TICKS = 4095,
    parameter int         ROM_AW        = 8
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              mid_pulse,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    output logic              sccb_rw,
    output logic [6:0]        sccb_ip_addr,
    output logic [7:0]        sccb_sub_addr,
    output logic [7:0]        sccb_data_in,
    input  logic [7:0]        sccb_data_out,
    input  logic              sccb_done,
    input  logic              host_req,
    input  logic              host_rw,
    input  logic [7:0]        host_sub_addr,
    input  logic [7:0]        host_wdata,
    output logic              host_ack,
    output logic [7:0]        host_rdata,
    output logic              init_busy,
    output logic              init_done,
    output logic              init_err,
    output logic [1:0]        err_code,
    output logic [ROM_AW-1:0] entry_cnt
);

    localparam logic [3:0] c_ST_PWRUP        = 4'd0;
    localparam logic [3:0] c_ST_ID_RD        = 4'd1;
    localparam logic [3:0] c_ST_ID_WAIT      = 4'd2;
    localparam logic [3:0] c_ST_FETCH        = 4'd3;
    localparam logic [3:0] c_ST_ISSUE        = 4'd4;
    localparam logic [3:0] c_ST_WAIT_DONE    = 4'd5;
    localparam logic [3:0] c_ST_RELEASE      = 4'd6;
    localparam logic [3:0] c_ST_DELAY        = 4'd7;
    localparam logic [3:0] c_ST_READY        = 4'd8;
    localparam logic [3:0] c_ST_HOST_WAIT    = 4'd9;
    localparam logic [3:0] c_ST_HOST_RELEASE = 4'd10;
    localparam logic [3:0] c_ST_FAIL         = 4'd11;

    localparam logic [1:0]        c_ERR_ID      = 2'b01;
    localparam logic [1:0]        c_ERR_TIMEOUT = 2'b10;
    localparam logic [1:0]        c_ERR_OVERRUN = 2'b11;
    localparam logic [31:0]       c_PWRUP_LAST  = 32'(PWRUP_TICKS - 1);
    localparam logic [31:0]       c_TMO_LAST    = 32'(TIMEOUT_TICKS - 1);
    localparam logic [31:0]       c_DLY_UNIT    = 32'(DELAY_UNIT);
    localparam logic [ROM_AW-1:0] c_ADDR_MAX    = '1;
    localparam logic [ROM_AW-1:0] c_AW_ONE      = {{(ROM_AW-1){1'b0}}, 1'b1};

    logic [3:0]        r_state;
    logic [31:0]       r_cnt;
    logic [ROM_AW-1:0] r_rom_addr;
    logic              r_rom_stale;
    logic              r_addr_wrap;
    logic              r_start;
    logic              r_rw;
    logic [7:0]        r_sub_addr;
    logic [7:0]        r_wdata;
    logic              r_host_ack;
    logic [7:0]        r_host_rdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [ROM_AW-1:0] r_entry_cnt;

    logic              w_end_marker;
    logic              w_delay_marker;
    logic [31:0]       w_dly_ticks;
    logic              w_timeout;

    assign w_end_marker   = (rom_data == 16'hFFFF);
    assign w_delay_marker = (rom_data[15:8] == 8'hFF) && !w_end_marker;
    assign w_dly_ticks    = {24'd0, rom_data[7:0]} * c_DLY_UNIT;
    assign w_timeout      = (r_cnt == c_TMO_LAST);

    // Sequencer FSM; state and counters only move on mid_pulse, ack/stale flags are 1-PCLK
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state      <= c_ST_PWRUP;
            r_cnt        <= 32'd0;
            r_rom_addr   <= '0;
            r_rom_stale  <= 1'b0;
            r_addr_wrap  <= 1'b0;
            r_start      <= 1'b0;
            r_rw         <= 1'b0;
            r_sub_addr   <= 8'h00;
            r_wdata      <= 8'h00;
            r_host_ack   <= 1'b0;
            r_host_rdata <= 8'h00;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= 2'b00;
            r_entry_cnt  <= '0;
        end else begin
            r_host_ack  <= 1'b0;
            r_rom_stale <= 1'b0;
            if (mid_pulse) begin
                case (r_state)
                    c_ST_PWRUP: begin
                        if (r_cnt == c_PWRUP_LAST) begin
                            r_cnt   <= 32'd0;
                            r_state <= c_ST_ID_RD;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_ST_ID_RD: begin
                        r_rw       <= 1'b1;
                        r_sub_addr <= ID_SUB_ADDR;
                        r_start    <= 1'b1;
                        r_cnt      <= 32'd0;
                        r_state    <= c_ST_ID_WAIT;
                    end
                    c_ST_ID_WAIT: begin
                        if (sccb_done) begin
                            r_start <= 1'b0;
                            if (sccb_data_out == ID_EXPECT) begin
                                r_state <= c_ST_RELEASE;
                            end else begin
                                r_err_code <= c_ERR_ID;
                                r_err      <= 1'b1;
                                r_busy     <= 1'b0;
                                r_state    <= c_ST_FAIL;
                            end
                        end else if (w_timeout) begin
                            r_start    <= 1'b0;
                            r_err_code <= c_ERR_TIMEOUT;
                            r_err      <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= c_ST_FAIL;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_ST_FETCH: begin
                        // rom_data lags rom_addr by one PCLK; skip a pulse that lands too early
                        if (!r_rom_stale) begin
                            if (r_addr_wrap) begin
                                r_err_code <= c_ERR_OVERRUN;
                                r_err      <= 1'b1;
                                r_busy     <= 1'b0;
                                r_state    <= c_ST_FAIL;
                            end else if (w_end_marker) begin
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_state <= c_ST_READY;
                            end else begin
                                r_rom_addr  <= r_rom_addr + c_AW_ONE;
                                r_rom_stale <= 1'b1;
                                if (r_rom_addr == c_ADDR_MAX) begin
                                    r_addr_wrap <= 1'b1;
                                end
                                if (w_delay_marker) begin
                                    // A zero-length delay simply moves on to the next entry
                                    if (rom_data[7:0] != 8'h00) begin
                                        r_cnt   <= w_dly_ticks;
                                        r_state <= c_ST_DELAY;
                                    end
                                end else begin
                                    r_rw       <= 1'b0;
                                    r_sub_addr <= rom_data[15:8];
                                    r_wdata    <= rom_data[7:0];
                                    r_state    <= c_ST_ISSUE;
                                end
                            end
                        end
                    end
                    c_ST_ISSUE: begin
                        r_start <= 1'b1;
                        r_cnt   <= 32'd0;
                        r_state <= c_ST_WAIT_DONE;
                    end
                    c_ST_WAIT_DONE: begin
                        if (sccb_done) begin
                            r_start     <= 1'b0;
                            r_entry_cnt <= r_entry_cnt + c_AW_ONE;
                            r_state     <= c_ST_RELEASE;
                        end else if (w_timeout) begin
                            r_start    <= 1'b0;
                            r_err_code <= c_ERR_TIMEOUT;
                            r_err      <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= c_ST_FAIL;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_ST_RELEASE: begin
                        // Never raise start again while CoreSCCB still shows done
                        if (!sccb_done) begin
                            r_state <= c_ST_FETCH;
                        end
                    end
                    c_ST_DELAY: begin
                        if (r_cnt <= 32'd1) begin
                            r_cnt   <= 32'd0;
                            r_state <= c_ST_FETCH;
                        end else begin
                            r_cnt <= r_cnt - 32'd1;
                        end
                    end
                    c_ST_READY: begin
                        if (host_req) begin
                            r_rw       <= host_rw;
                            r_sub_addr <= host_sub_addr;
                            r_wdata    <= host_wdata;
                            r_start    <= 1'b1;
                            r_cnt      <= 32'd0;
                            r_state    <= c_ST_HOST_WAIT;
                        end
                    end
                    c_ST_HOST_WAIT: begin
                        if (sccb_done) begin
                            r_start    <= 1'b0;
                            r_host_ack <= 1'b1;
                            if (r_rw) begin
                                r_host_rdata <= sccb_data_out;
                            end
                            r_state <= c_ST_HOST_RELEASE;
                        end else if (w_timeout) begin
                            // Host timeouts are reported to the host only; init status is untouched
                            r_start      <= 1'b0;
                            r_host_ack   <= 1'b1;
                            r_host_rdata <= 8'hFF;
                            r_state      <= c_ST_HOST_RELEASE;
                        end else begin
                            r_cnt <= r_cnt + 32'd1;
                        end
                    end
                    c_ST_HOST_RELEASE: begin
                        if (!sccb_done) begin
                            r_state <= c_ST_READY;
                        end
                    end
                    c_ST_FAIL: begin
                        // Bus stays idle; host requests are answered with 0xFF straight away
                        r_start <= 1'b0;
                        if (host_req) begin
                            r_host_ack   <= 1'b1;
                            r_host_rdata <= 8'hFF;
                        end
                    end
                    default: begin
                        r_start <= 1'b0;
                        r_state <= c_ST_FAIL;
                    end
                endcase
            end
        end
    end

    assign rom_addr      = r_rom_addr;
    assign sccb_start    = r_start;
    assign sccb_rw       = r_rw;
    assign sccb_ip_addr  = IP_ADDR;
    assign sccb_sub_addr = r_sub_addr;
    assign sccb_data_in  = r_wdata;
    assign host_ack      = r_host_ack;
    assign host_rdata    = r_host_rdata;
    assign init_busy     = r_busy;
    assign init_done     = r_done;
    assign init_err      = r_err;
    assign err_code      = r_err_code;
    assign entry_cnt     = r_entry_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sccb_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccb_init_sequencer
// Description : Self-checking bench for sccb_init_sequencer with a CoreSCCB
//               responder model, a registered ROM and a transaction scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sccb_init_sequencer;

    localparam int AW      = 8;
    localparam int TMO     = 4095;
    localparam int LAT     = 6;    // PCLK cycles from start seen to done
    localparam int HOLD    = 10;   // PCLK cycles done stays high after start drops (5 ticks)
    localparam int BUDGET  = 20000;

    typedef struct packed {
        logic       rw;
        logic [7:0] sub;
        logic [7:0] data;
    } txn_t;

    typedef struct {
        logic [7:0] id;
        int         hang;
        bit         host;
        logic       exp_done;
        logic       exp_err;
        logic [1:0] exp_code;
        int         exp_entry;
        int         exp_rom;
    } vec_t;

    logic          PCLK = 1'b0;
    logic          PRESETN = 1'b0;
    logic          mid_pulse = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data = 16'h0000;
    logic          sccb_start;
    logic          sccb_rw;
    logic [6:0]    sccb_ip_addr;
    logic [7:0]    sccb_sub_addr;
    logic [7:0]    sccb_data_in;
    logic [7:0]    sccb_data_out;
    logic          sccb_done;
    logic          host_req = 1'b0;
    logic          host_rw = 1'b0;
    logic [7:0]    host_sub_addr = 8'h00;
    logic [7:0]    host_wdata = 8'h00;
    logic          host_ack;
    logic [7:0]    host_rdata;
    logic          init_busy;
    logic          init_done;
    logic          init_err;
    logic [1:0]    err_code;
    logic [AW-1:0] entry_cnt;

    sccb_init_sequencer dut (
        .PCLK          (PCLK),
        .PRESETN       (PRESETN),
        .mid_pulse     (mid_pulse),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .sccb_start    (sccb_start),
        .sccb_rw       (sccb_rw),
        .sccb_ip_addr  (sccb_ip_addr),
        .sccb_sub_addr (sccb_sub_addr),
        .sccb_data_in  (sccb_data_in),
        .sccb_data_out (sccb_data_out),
        .sccb_done     (sccb_done),
        .host_req      (host_req),
        .host_rw       (host_rw),
        .host_sub_addr (host_sub_addr),
        .host_wdata    (host_wdata),
        .host_ack      (host_ack),
        .host_rdata    (host_rdata),
        .init_busy     (init_busy),
        .init_done     (init_done),
        .init_err      (init_err),
        .err_code      (err_code),
        .entry_cnt     (entry_cnt)
    );

    always #5 PCLK = ~PCLK;

    // mid_pulse every second PCLK, plus a tick counter
    int tick = 0;
    always @(posedge PCLK) begin
        mid_pulse <= ~mid_pulse;
        if (mid_pulse) tick <= tick + 1;
    end

    // Registered table ROM
    logic [15:0] rom [256];
    always @(posedge PCLK) rom_data <= rom[rom_addr];

    // CoreSCCB responder; logs every start rise for the scoreboard
    logic [7:0] model_id = 8'h76;
    int         hang_n = 0;
    int         m_state, m_cnt, m_wr_idx;
    logic       m_hang;
    txn_t       obs_arr [64];
    int         obs_wr = 0;
    always @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            m_state <= 0; m_cnt <= 0; m_wr_idx <= 0; m_hang <= 1'b0;
            sccb_done <= 1'b0; sccb_data_out <= 8'h00;
        end else begin
            case (m_state)
                0: if (sccb_start) begin
                    obs_arr[obs_wr % 64] <= '{rw: sccb_rw, sub: sccb_sub_addr, data: sccb_data_in};
                    obs_wr <= obs_wr + 1;
                    if (!sccb_rw) m_wr_idx <= m_wr_idx + 1;
                    m_hang  <= !sccb_rw && ((m_wr_idx + 1) == hang_n);
                    m_cnt   <= 0;
                    m_state <= 1;
                end
                1: if (!sccb_start) m_state <= 0;
                   else if (!m_hang && m_cnt >= LAT) begin
                       sccb_done     <= 1'b1;
                       sccb_data_out <= (sccb_sub_addr == 8'h0A) ? model_id :
                                        (sccb_sub_addr == 8'h0B) ? 8'h70 : 8'h00;
                       m_state <= 2;
                   end else m_cnt <= m_cnt + 1;
                2: if (!sccb_start) begin m_cnt <= 0; m_state <= 3; end
                3: if (m_cnt >= HOLD) begin sccb_done <= 1'b0; m_state <= 0; end
                   else m_cnt <= m_cnt + 1;
                default: m_state <= 0;
            endcase
        end
    end

    // Protocol monitor: start-while-done, ack width, start rise/fall tick stamps
    int   n_rise = 0, n_ack = 0, n_ack_early = 0, n_ack_wide = 0, n_restart_viol = 0;
    int   rise_arr [64];
    int   mon_rise = 0, last_dur = 0;
    logic mon_prev_start = 1'b0, mon_prev_ack = 1'b0;
    always @(negedge PCLK) begin
        if (sccb_start && !mon_prev_start) begin
            if (sccb_done) n_restart_viol++;
            rise_arr[n_rise % 64] = tick;
            n_rise++;
            mon_rise = tick;
        end
        if (!sccb_start && mon_prev_start) last_dur = tick - mon_rise;
        if (host_ack) begin
            n_ack++;
            if (!init_done && !init_err) n_ack_early++;
            if (mon_prev_ack) n_ack_wide++;
        end
        mon_prev_start = sccb_start;
        mon_prev_ack   = host_ack;
    end

    int   n_checks = 0;
    int   n_fail = 0;
    txn_t exp_q [$];
    int   obs_rd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pop expected transactions for every start the responder has seen
    task automatic sb_drain();
        txn_t o, e;
        while (obs_rd != obs_wr) begin
            o = obs_arr[obs_rd % 64];
            obs_rd++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected_txn: got rw=%0d sub=0x%0h data=0x%0h, expected none", o.rw, o.sub, o.data);
            end else begin
                e = exp_q.pop_front();
                check("sb_rw", {31'd0, o.rw}, {31'd0, e.rw});
                check("sb_sub_addr", {24'd0, o.sub}, {24'd0, e.sub});
                if (!e.rw) check("sb_wdata", {24'd0, o.data}, {24'd0, e.data});
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PCLK);
            sb_drain();
        end
    endtask

    task automatic wait_init(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge PCLK);
            sb_drain();
            if (init_done || init_err) return;
        end
        check("wait_init_timeout", {31'd0, init_done | init_err}, 32'd1);
    endtask

    task automatic wait_ack(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge PCLK);
            sb_drain();
            if (host_ack) return;
        end
        check("wait_ack_timeout", {31'd0, host_ack}, 32'd1);
    endtask

    task automatic push_init(input bit id_ok);
        exp_q.push_back('{rw: 1'b1, sub: 8'h0A, data: 8'h00});
        if (id_ok) begin
            exp_q.push_back('{rw: 1'b0, sub: 8'h12, data: 8'h80});
            exp_q.push_back('{rw: 1'b0, sub: 8'h11, data: 8'h01});
        end
    endtask

    task automatic check_reset();
        check("rst_start", {31'd0, sccb_start}, 32'd0);
        check("rst_busy", {31'd0, init_busy}, 32'd1);
        check("rst_done", {31'd0, init_done}, 32'd0);
        check("rst_err", {31'd0, init_err}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_entry_cnt", {24'd0, entry_cnt}, 32'd0);
        check("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("rst_host_rdata", {24'd0, host_rdata}, 32'd0);
        check("ip_addr", {25'd0, sccb_ip_addr}, 32'h21);
    endtask

    task automatic run_vec(input vec_t v);
        int rise_base, ack_base, early_base;
        PRESETN  = 1'b0;
        host_req = 1'b0;
        model_id = v.id;
        hang_n   = v.hang;
        step(3);
        check_reset();
        push_init(v.id == 8'h76);
        if (v.host) exp_q.push_back('{rw: 1'b1, sub: 8'h0B, data: 8'h00});
        rise_base  = n_rise;
        ack_base   = n_ack;
        early_base = n_ack_early;
        PRESETN = 1'b1;
        if (v.host) begin
            host_req = 1'b1; host_rw = 1'b1; host_sub_addr = 8'h0B; host_wdata = 8'h00;
        end
        wait_init(BUDGET);
        step(4);
        check("init_done", {31'd0, init_done}, {31'd0, v.exp_done});
        check("init_err", {31'd0, init_err}, {31'd0, v.exp_err});
        check("init_busy", {31'd0, init_busy}, 32'd0);
        check("err_code", {30'd0, err_code}, {30'd0, v.exp_code});
        check("entry_cnt", {24'd0, entry_cnt}, 32'(v.exp_entry));
        check("rom_addr", {24'd0, rom_addr}, 32'(v.exp_rom));
        if (v.exp_done)
            check("delay_gap_ok", {31'd0, (rise_arr[(rise_base + 2) % 64] - rise_arr[(rise_base + 1) % 64]) >= 600 &&
                                    (rise_arr[(rise_base + 2) % 64] - rise_arr[(rise_base + 1) % 64]) < 700}, 32'd1);
        if (v.exp_code == 2'b10)
            check("timeout_dur_ok", {31'd0, last_dur >= TMO && last_dur <= TMO + 1}, 32'd1);
        if (v.host) begin
            wait_ack(400);
            host_req = 1'b0;
            check("host_rdata", {24'd0, host_rdata}, 32'h70);
            step(30);
            check("host_ack_early", 32'(n_ack_early - early_base), 32'd0);
            check("host_ack_count", 32'(n_ack - ack_base), 32'd1);
            check("host_rise_count", 32'(n_rise - rise_base), 32'd4);
        end
        if (v.exp_err && v.exp_code == 2'b01) begin
            // FAIL state: immediate 0xFF answer with no bus activity
            rise_base = n_rise;
            ack_base  = n_ack;
            host_req = 1'b1; host_rw = 1'b1; host_sub_addr = 8'h0B;
            wait_ack(8);
            host_req = 1'b0;
            step(10);
            check("fail_host_rdata", {24'd0, host_rdata}, 32'hFF);
            check("fail_host_acks", 32'(n_ack - ack_base), 32'd1);
            check("fail_no_bus", 32'(n_rise - rise_base), 32'd0);
        end
        step(20);
        check("sb_pending", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs [3];

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFF02;
        rom[2] = 16'h1101;
        rom[3] = 16'hFFFF;

        //          id     hang host done  err   code   entry rom
        vecs[0] = '{8'h76, 0,   1,   1'b1, 1'b0, 2'b00, 2,    3};
        vecs[1] = '{8'h73, 0,   0,   1'b0, 1'b1, 2'b01, 0,    0};
        vecs[2] = '{8'h76, 2,   0,   1'b0, 1'b1, 2'b10, 1,    3};

        for (int k = 0; k < 3; k++) run_vec(vecs[k]);

        // Reset while the first table write is outstanding
        PRESETN  = 1'b0;
        model_id = 8'h76;
        hang_n   = 1;
        step(3);
        push_init(1'b0);
        exp_q.push_back('{rw: 1'b0, sub: 8'h12, data: 8'h80});
        PRESETN = 1'b1;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge PCLK);
            sb_drain();
            if (sccb_start && !sccb_rw) break;
        end
        step(10);
        check("wd_start_held", {31'd0, sccb_start}, 32'd1);
        #1 PRESETN = 1'b0;
        #1;
        check("wd_rst_start", {31'd0, sccb_start}, 32'd0);
        check("wd_rst_busy", {31'd0, init_busy}, 32'd1);
        check("wd_rst_rom_addr", {24'd0, rom_addr}, 32'd0);
        hang_n = 0;
        step(3);
        check("wd_sb_pending", 32'(exp_q.size()), 32'd0);
        push_init(1'b1);
        PRESETN = 1'b1;
        wait_init(BUDGET);
        step(20);
        check("wd_restart_done", {31'd0, init_done}, 32'd1);
        check("wd_restart_entries", {24'd0, entry_cnt}, 32'd2);
        check("wd_restart_sb", 32'(exp_q.size()), 32'd0);

        check("start_while_done", 32'(n_restart_viol), 32'd0);
        check("ack_width", 32'(n_ack_wide), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
